// File: rtl/md_sequencer.sv
// EX-stage multiply/divide sequencer: latches operands, drives the divider handshake,
// times the fixed multiplier latency, stalls the pipe and issues one HI/LO write.
module md_sequencer #(
  parameter int unsigned MUL_LAT     = 2,
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        stall_ex,
  input  logic        flush,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_ina_o,
  output logic [31:0] mul_inb_o,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state_r, next_s;
  logic [3:0]  cnt_r;
  logic [31:0] opa_r, opb_r;
  logic        signed_r;
  logic [31:0] hi_r, lo_r;
  logic        first_r;
  logic        accept_s, cap_mul_s, cap_div_s, div_zero_s;

  // Next-state, handshake and stall decode; flush outranks ready and counter expiry.
  always_comb begin
    next_s      = state_r;
    accept_s    = 1'b0;
    cap_mul_s   = 1'b0;
    cap_div_s   = 1'b0;
    div_zero_s  = 1'b0;
    stallreq_o  = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    hilo_we_o   = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_valid && !flush) begin
          accept_s   = 1'b1;
          stallreq_o = 1'b1;
          if (!op_type[1]) begin
            next_s = MUL_WAIT;
          end else if (src_b == 32'd0) begin
            div_zero_s = 1'b1;
            next_s     = DONE;
          end else begin
            next_s = DIV_RUN;
          end
        end else begin
          next_s = IDLE;
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          next_s = IDLE;
        end else begin
          stallreq_o = 1'b1;
          if (cnt_r == 4'd0) begin
            cap_mul_s = 1'b1;
            next_s    = DONE;
          end else begin
            next_s = MUL_WAIT;
          end
        end
      end
      DIV_RUN: begin
        if (flush) begin
          div_annul_o = 1'b1;
          next_s      = IDLE;
        end else if (div_ready_i) begin
          cap_div_s = 1'b1;
          next_s    = DONE;
        end else begin
          div_start_o = 1'b1;
          stallreq_o  = 1'b1;
          next_s      = DIV_RUN;
        end
      end
      DONE: begin
        if (flush) begin
          next_s = IDLE;
        end else begin
          hilo_we_o = first_r;
          if (stall_ex) begin
            next_s = DONE;
          end else begin
            next_s = IDLE;
          end
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Operands are only presented to the unit that is currently working on them.
  always_comb begin
    mul_signed_o  = (state_r == MUL_WAIT) ? signed_r : 1'b0;
    mul_ina_o     = (state_r == MUL_WAIT) ? opa_r    : 32'd0;
    mul_inb_o     = (state_r == MUL_WAIT) ? opb_r    : 32'd0;
    div_signed_o  = (state_r == DIV_RUN)  ? signed_r : 1'b0;
    div_opdata1_o = (state_r == DIV_RUN)  ? opa_r    : 32'd0;
    div_opdata2_o = (state_r == DIV_RUN)  ? opb_r    : 32'd0;
    busy_o        = (state_r != IDLE);
    hi_o          = hi_r;
    lo_o          = lo_r;
  end

  // State, operand latches, latency counter and result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      opa_r    <= 32'd0;
      opb_r    <= 32'd0;
      signed_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      first_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      first_r <= (next_s == DONE) && (state_r != DONE);
      if (accept_s) begin
        opa_r    <= src_a;
        opb_r    <= src_b;
        signed_r <= ~op_type[0];
        cnt_r    <= 4'(MUL_LAT - 1);
      end else if ((state_r == MUL_WAIT) && !flush && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (div_zero_s) begin
        hi_r <= src_a;
        lo_r <= DIV_ZERO_LO;
      end else if (cap_mul_s) begin
        hi_r <= mul_result_i[63:32];
        lo_r <= mul_result_i[31:0];
      end else if (cap_div_s) begin
        hi_r <= div_result_i[63:32];
        lo_r <= div_result_i[31:0];
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: multiply, divide, divide-by-zero, flush, EX stall, reset.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a, src_b;
  logic        stall_ex, flush;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic [63:0] mul_result_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        mul_signed_o;
  logic [31:0] mul_ina_o, mul_inb_o;
  logic        stallreq_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;
  logic        busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  md_sequencer #(.MUL_LAT(2), .DIV_ZERO_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type),
    .src_a(src_a), .src_b(src_b), .stall_ex(stall_ex), .flush(flush),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i), .mul_result_i(mul_result_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .mul_signed_o(mul_signed_o), .mul_ina_o(mul_ina_o), .mul_inb_o(mul_inb_o),
    .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Multiplier model: full 64-bit product of whatever operands are presented.
  always_comb begin
    mul_result_i = {{32{mul_ina_o[31] & mul_signed_o}}, mul_ina_o} *
                   {{32{mul_inb_o[31] & mul_signed_o}}, mul_inb_o};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00; src_a = 32'd0; src_b = 32'd0;
    stall_ex = 1'b0; flush = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0;
    #3;
    tests_run++;
    if ({busy_o, stallreq_o, hilo_we_o, div_start_o, div_annul_o} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctrl got %b exp 00000",
        {busy_o, stallreq_o, hilo_we_o, div_start_o, div_annul_o});
    end
    tick; tick;
    tests_run++;
    if ({hi_o, lo_o, mul_ina_o, div_opdata1_o} !== 128'd0) begin
      tests_failed++; $display("FAIL reset_data got %h exp 0", {hi_o, lo_o, mul_ina_o, div_opdata1_o});
    end
    resetn = 1'b1;
  endtask

  task automatic test_multu;
    int n_stall = 0;
    int n_we = 0;
    logic [31:0] hi_seen = 32'd0;
    logic [31:0] lo_seen = 32'd0;
    tick;
    op_valid = 1'b1; op_type = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick; op_valid = 1'b0; end
      #2;
      if (stallreq_o) n_stall++;
      if (hilo_we_o) begin n_we++; hi_seen = hi_o; lo_seen = lo_o; end
    end
    tests_run++;
    if (n_stall != 3) begin tests_failed++; $display("FAIL multu_stall got %0d exp 3", n_stall); end
    tests_run++;
    if (n_we != 1) begin tests_failed++; $display("FAIL multu_we got %0d exp 1", n_we); end
    tests_run++;
    if ({hi_seen, lo_seen} !== 64'h0000_0001_FFFF_FFFE) begin
      tests_failed++; $display("FAIL multu_result got %h exp 00000001fffffffe", {hi_seen, lo_seen});
    end
  endtask

  task automatic test_mult;
    int n_wait = 0;
    int n_bad = 0;
    logic [63:0] res = 64'd0;
    tick;
    op_valid = 1'b1; op_type = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick; op_valid = 1'b0; end
      #2;
      if (busy_o && stallreq_o) begin
        n_wait++;
        if (!mul_signed_o || mul_ina_o !== 32'hFFFF_FFFD || mul_inb_o !== 32'd5) n_bad++;
      end
      if (hilo_we_o) res = {hi_o, lo_o};
    end
    tests_run++;
    if (n_wait != 2 || n_bad != 0) begin
      tests_failed++; $display("FAIL mult_operands got wait=%0d bad=%0d exp wait=2 bad=0", n_wait, n_bad);
    end
    tests_run++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      tests_failed++; $display("FAIL mult_result got %h exp fffffffffffffff1", res);
    end
  endtask

  task automatic test_div;
    int n_bad = 0;
    tick;
    op_valid = 1'b1; op_type = 2'b10; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    div_result_i = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    #2;
    tests_run++;
    if ({stallreq_o, div_start_o} !== 2'b10) begin
      tests_failed++; $display("FAIL div_accept got %b exp 10", {stallreq_o, div_start_o});
    end
    for (int k = 0; k < 33; k++) begin
      tick; op_valid = 1'b0; #2;
      if (!(div_start_o && stallreq_o && div_signed_o && div_opdata1_o === 32'hFFFF_FFF9 &&
            div_opdata2_o === 32'd2)) n_bad++;
    end
    tests_run++;
    if (n_bad != 0) begin tests_failed++; $display("FAIL div_run got %0d bad cycles exp 0", n_bad); end
    tick; div_ready_i = 1'b1; #2;
    tests_run++;
    if ({div_start_o, stallreq_o} !== 2'b00) begin
      tests_failed++; $display("FAIL div_ready_drop got %b exp 00", {div_start_o, stallreq_o});
    end
    tick; div_ready_i = 1'b0; #2;
    tests_run++;
    if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      tests_failed++; $display("FAIL div_result got we=%b %h_%h exp we=1 ffffffff_fffffffd", hilo_we_o, hi_o, lo_o);
    end
    tick; #2;
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL div_idle got %b exp 0", busy_o); end
  endtask

  task automatic test_divzero;
    int n_start = 0;
    tick;
    op_valid = 1'b1; op_type = 2'b11; src_a = 32'd5; src_b = 32'd0;
    #2;
    if (div_start_o) n_start++;
    tests_run++;
    if (stallreq_o !== 1'b1) begin tests_failed++; $display("FAIL divz_stall got %b exp 1", stallreq_o); end
    tick; op_valid = 1'b0; #2;
    if (div_start_o) n_start++;
    tests_run++;
    if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
      tests_failed++; $display("FAIL divz_result got we=%b %h_%h exp we=1 00000005_ffffffff", hilo_we_o, hi_o, lo_o);
    end
    tick; #2;
    if (div_start_o) n_start++;
    tests_run++;
    if (n_start != 0 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL divz_nostart got start=%0d busy=%b exp 0 0", n_start, busy_o);
    end
  endtask

  task automatic test_flush;
    int n_we = 0;
    tick;
    op_valid = 1'b1; op_type = 2'b10; src_a = 32'd100; src_b = 32'd7; flush = 1'b1;
    #2;
    tests_run++;
    if (stallreq_o !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_stall got %b exp 0", stallreq_o); end
    tick; flush = 1'b0; op_valid = 1'b0; #2;
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_accept got %b exp 0", busy_o); end
    tick; op_valid = 1'b1; div_result_i = {32'd2, 32'd14};
    for (int i = 1; i < 10; i++) begin
      tick; op_valid = 1'b0; #2;
      if (hilo_we_o) n_we++;
    end
    tick; flush = 1'b1; #2;
    tests_run++;
    if ({div_annul_o, div_start_o, stallreq_o, hilo_we_o} !== 4'b1000) begin
      tests_failed++; $display("FAIL flush_annul got %b exp 1000", {div_annul_o, div_start_o, stallreq_o, hilo_we_o});
    end
    tick; flush = 1'b0; #2;
    tests_run++;
    if ({busy_o, div_annul_o} !== 2'b00) begin
      tests_failed++; $display("FAIL flush_after got %b exp 00", {busy_o, div_annul_o});
    end
    tick; div_ready_i = 1'b1; #2;
    if (hilo_we_o) n_we++;
    tick; div_ready_i = 1'b0; #2;
    if (hilo_we_o) n_we++;
    tests_run++;
    if (n_we != 0 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_late_ready got we=%0d busy=%b exp 0 0", n_we, busy_o);
    end
  endtask

  task automatic test_stall_ex;
    int n_we = 0;
    int n_stall = 0;
    tick;
    op_valid = 1'b1; op_type = 2'b01; src_a = 32'd3; src_b = 32'd4;
    tick; stall_ex = 1'b1;
    tick;
    for (int i = 3; i < 6; i++) begin
      tick; #2;
      if (hilo_we_o) begin
        n_we++;
        tests_run++;
        if ({hi_o, lo_o} !== 64'd12) begin
          tests_failed++; $display("FAIL stallex_result got %h exp 000000000000000c", {hi_o, lo_o});
        end
      end
      if (stallreq_o) n_stall++;
    end
    tick; stall_ex = 1'b0; #2;
    if (hilo_we_o) n_we++;
    if (stallreq_o) n_stall++;
    tests_run++;
    if (n_we != 1 || n_stall != 0 || busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL stallex_hold got we=%0d stall=%0d busy=%b exp 1 0 1", n_we, n_stall, busy_o);
    end
    tick; op_type = 2'b11; src_a = 32'd9; src_b = 32'd0; #2;
    tests_run++;
    if ({busy_o, stallreq_o} !== 2'b01) begin
      tests_failed++; $display("FAIL stallex_new_accept got %b exp 01", {busy_o, stallreq_o});
    end
    tick; op_valid = 1'b0; #2;
    tests_run++;
    if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'd9, 32'hFFFF_FFFF}) begin
      tests_failed++; $display("FAIL stallex_new_result got we=%b %h_%h exp we=1 00000009_ffffffff", hilo_we_o, hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid_div;
    tick;
    op_valid = 1'b1; op_type = 2'b10; src_a = 32'd100; src_b = 32'd7;
    tick; op_valid = 1'b0;
    tick; #2;
    tests_run++;
    if (div_start_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pre got %b exp 1", div_start_o); end
    #1 resetn = 1'b0;
    #1;
    tests_run++;
    if ({busy_o, stallreq_o, div_start_o, div_annul_o, hilo_we_o, div_opdata1_o, hi_o, lo_o} !== 101'd0) begin
      tests_failed++; $display("FAIL rst_async got busy=%b stall=%b start=%b annul=%b we=%b d1=%h hi=%h lo=%h exp all 0",
        busy_o, stallreq_o, div_start_o, div_annul_o, hilo_we_o, div_opdata1_o, hi_o, lo_o);
    end
    tick; resetn = 1'b1;
    tick; #2;
    tests_run++;
    if ({busy_o, stallreq_o, div_start_o} !== 3'b000) begin
      tests_failed++; $display("FAIL rst_after got %b exp 000", {busy_o, stallreq_o, div_start_o});
    end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_divzero;
    test_flush;
    test_stall_ex;
    test_reset_mid_div;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Controls the EX-stage multi-cycle multiply/divide resources for MULT, MULTU, DIV and DIVU.
- Latches the operands, drives the iterative divider's start/annul handshake, and counts the fixed multiplier latency.
- Raises a pipeline stall request while an operation is in flight, then issues a single-cycle HI/LO write with the 64-bit result.
- Sits between the ID/EX register outputs and the div/mul units. Its stall request feeds the stall controller.

Parameters:
- MUL_LAT, 2, multiplier result latency in cycles after the operands are presented (range 1..15).
- DIV_ZERO_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- op_valid  in  1  the EX-stage instruction is a mul/div op.
- op_type  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- src_a  in  32  rs value.
- src_b  in  32  rt value.
- stall_ex  in  1  EX cannot advance this cycle (stall[3] from the stall controller).
- flush  in  1  kill the in-flight op.
- div_ready_i  in  1  divider result valid (1-cycle pulse).
- div_result_i  in  64  {remainder, quotient}.
- mul_result_i  in  64  {hi, lo} product.
- div_start_o  out  1  divider start, held high until ready.
- div_annul_o  out  1  divider abort pulse.
- div_signed_o  out  1  signed divide.
- div_opdata1_o  out  32  dividend.
- div_opdata2_o  out  32  divisor.
- mul_signed_o  out  1  signed multiply.
- mul_ina_o  out  32  multiplicand.
- mul_inb_o  out  32  multiplier.
- stallreq_o  out  1  stall request to the stall controller.
- hilo_we_o  out  1  HI/LO write enable.
- hi_o  out  32  HI write data.
- lo_o  out  32  LO write data.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: clk and resetn are the only clock/reset; reset is asynchronous and active-low.
  - State goes to IDLE and all registers clear.
  - Every output is 0 during and after reset until the first op.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE, op_valid=1, flush=0, op accepted:
  - Latch src_a, src_b and the signed flag (op_type[0]==0) into operand registers.
  - stallreq_o=1 combinationally in the accept cycle.
  - op_type[1]=0: load cnt=MUL_LAT-1 and go to MUL_WAIT.
  - op_type[1]=1 with src_b==0: set result {hi,lo}={src_a, DIV_ZERO_LO} and go to DONE. The divider is never started.
  - op_type[1]=1 with src_b!=0: go to DIV_RUN.
- Operand outputs:
  - mul_ina_o/mul_inb_o/mul_signed_o equal the latched operands in MUL_WAIT and 0 otherwise.
  - div_opdata*/div_signed_o equal the latched operands in DIV_RUN and 0 otherwise.
- MUL_WAIT:
  - stallreq_o=1.
  - cnt decrements each cycle.
  - When cnt==0, capture mul_result_i into the result register and go to DONE.
  - Total stall is MUL_LAT+1 cycles.
- DIV_RUN:
  - div_start_o=1 and stallreq_o=1.
  - When div_ready_i=1, capture {hi,lo}={div_result_i[63:32], div_result_i[31:0]}, drop start the same cycle, and go to DONE.
  - div_ready_i outside DIV_RUN is ignored.
- DONE:
  - stallreq_o=0.
  - hilo_we_o=1 only in the first DONE cycle, with hi_o/lo_o holding the result.
  - If stall_ex=0, go to IDLE.
  - If stall_ex=1, stay in DONE with hilo_we_o=0 and do not re-accept (op_valid is still the same instruction).
- IDLE with op_valid=0: nothing happens. op_valid with flush=1 in IDLE is not accepted.
- flush=1 in MUL_WAIT or DIV_RUN:
  - Go to IDLE next cycle with no hilo_we_o.
  - If in DIV_RUN, div_annul_o=1 for that one cycle and div_start_o=0.
  - stallreq_o=0 in the flush cycle.
- flush=1 in DONE: suppress hilo_we_o in that cycle and go to IDLE.
- flush has priority over div_ready_i and over cnt expiry.
- resetn deasserted mid-operation: immediate IDLE. The divider is not annulled, because it shares the reset.
- busy_o = (state != IDLE).

Test Plan:
- MULTU 0xFFFF_FFFF×2, MUL_LAT=2:
  - stallreq_o high 3 cycles.
  - One hilo_we_o pulse with hi=0x1, lo=0xFFFF_FFFE.
- MULT −3×5: hi=0xFFFF_FFFF, lo=0xFFFF_FFF1, mul_signed_o=1 throughout MUL_WAIT.
- DIV −7/2, divider model returns ready after 33 cycles:
  - div_start_o high until ready with operands stable.
  - Then hi=0xFFFF_FFFF (remainder −1), lo=0xFFFF_FFFD; stallreq_o drops the same cycle ready arrives.
- DIVU 5/0:
  - div_start_o never asserted.
  - Next cycle hilo_we_o with hi=5, lo=0xFFFF_FFFF.
- DIV in flight, flush at cycle 10:
  - div_annul_o one-cycle pulse, no hilo_we_o, busy_o=0 next cycle.
  - A later div_ready_i is ignored.
- Op completes while stall_ex=1 for 3 cycles:
  - Exactly one hilo_we_o pulse and no restart.
  - A new op is accepted on the cycle after stall_ex falls.
  - Separately: resetn pulsed low in DIV_RUN clears all outputs asynchronously.
